// File: rtl/stream_serializer_pkg.sv
// Shared types and default sizing for the stream serializer and its word buffer.
package serializer_pkg;

    localparam int unsigned SER_DATA_W     = 8;
    localparam int unsigned SER_FIFO_DEPTH = 4;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } ser_state_t;

endpackage

// File: rtl/stream_serializer_if.sv
// Word-in / bit-out bundle of the stream serializer; master is the producer/observer side.
interface stream_serializer_if #(
    parameter int unsigned DATA_W     = serializer_pkg::SER_DATA_W,
    parameter int unsigned FIFO_DEPTH = serializer_pkg::SER_FIFO_DEPTH
);

    localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              stream_out;
    logic              stream_valid;
    logic              busy;
    logic [LevelW-1:0] fifo_level;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  stream_out,
        input  stream_valid,
        input  busy,
        input  fifo_level
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output stream_out,
        output stream_valid,
        output busy,
        output fifo_level
    );

endinterface

// File: rtl/stream_serializer_sync_fifo.sv
// Single-clock word FIFO with first-word fall-through head and occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned LevelW = PtrW + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PtrW-1:0]   wptr_q;
    logic [PtrW-1:0]   rptr_q;
    logic [LevelW-1:0] level_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (level_q == LevelW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rptr_q];
    // Guard against misuse so the occupancy count can never leave 0..DEPTH.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LevelW'(1);
                2'b01:   level_q <= level_q - LevelW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/stream_serializer.sv
// Buffers parallel words and emits them one bit per clock as a gapless serial stream.
module stream_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned DATA_W     = SER_DATA_W,
    parameter int unsigned FIFO_DEPTH = SER_FIFO_DEPTH,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_BIT   = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    stream_serializer_if.slave bus
);

    localparam int unsigned CntW   = $clog2(DATA_W);
    localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

    ser_state_t        state_q;
    logic [DATA_W-1:0] sreg_q;
    logic [DATA_W-1:0] sreg_shift;
    logic [CntW-1:0]   cnt_q;
    logic              stream_out_q;
    logic              stream_valid_q;
    logic              ready_en_q;

    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LevelW-1:0] fifo_level;
    logic              push;
    logic              pop;
    logic              word_done;

    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    // ready_en_q keeps in_ready low until the first edge after reset release.
    assign bus.in_ready = ready_en_q && !fifo_full;
    assign push         = bus.in_valid && bus.in_ready;

    // A new word is loaded either from idle or on the last bit of the current word.
    assign word_done = (state_q == StIdle) || (cnt_q == '0);
    assign pop       = word_done && !fifo_empty;

    assign sreg_shift = MSB_FIRST ? {sreg_q[DATA_W-2:0], 1'b0} : {1'b0, sreg_q[DATA_W-1:1]};

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            sreg_q         <= '0;
            cnt_q          <= '0;
            stream_out_q   <= IDLE_BIT;
            stream_valid_q <= 1'b0;
            ready_en_q     <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (pop) begin
                state_q        <= StShift;
                sreg_q         <= fifo_dout;
                cnt_q          <= CntW'(DATA_W - 1);
                stream_out_q   <= head_bit(fifo_dout);
                stream_valid_q <= 1'b1;
            end else if (state_q == StShift) begin
                if (cnt_q == '0) begin
                    state_q        <= StIdle;
                    stream_out_q   <= IDLE_BIT;
                    stream_valid_q <= 1'b0;
                end else begin
                    sreg_q       <= sreg_shift;
                    cnt_q        <= cnt_q - CntW'(1);
                    stream_out_q <= head_bit(sreg_shift);
                end
            end
        end
    end

    assign bus.stream_out   = stream_out_q;
    assign bus.stream_valid = stream_valid_q;
    assign bus.busy         = (state_q == StShift) || !fifo_empty;
    assign bus.fifo_level   = fifo_level;

endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench for stream_serializer: scoreboarded bit stream, latency, backpressure, reset.
module tb_stream_serializer;

    localparam int unsigned DW = 8;
    localparam int unsigned FD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    stream_serializer_if #(.DATA_W(DW), .FIFO_DEPTH(FD)) bus0 ();
    stream_serializer_if #(.DATA_W(DW), .FIFO_DEPTH(FD)) bus1 ();

    stream_serializer #(
        .DATA_W     (DW),
        .FIFO_DEPTH (FD),
        .MSB_FIRST  (1'b1),
        .IDLE_BIT   (1'b0)
    ) u_dut0 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus0)
    );

    stream_serializer #(
        .DATA_W     (DW),
        .FIFO_DEPTH (FD),
        .MSB_FIRST  (1'b0),
        .IDLE_BIT   (1'b1)
    ) u_dut1 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus1)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    bit   exp_q [2][$];
    int   valid_cnt [2];
    int   runs [2];
    int   max_lvl [2];
    bit   prev_valid [2];
    logic ready_seen [2];

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_num(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // dut0 is MSB-first, dut1 is LSB-first.
    task automatic queue_bits(input int s, input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            exp_q[s].push_back((s == 0) ? w[7-i] : w[i]);
        end
    endtask

    task automatic mon_one(input int s, input logic v, input logic o, input logic [2:0] lvl,
                           input logic rdy, input logic idle);
        if (v === 1'b1) begin
            valid_cnt[s]++;
            if (!prev_valid[s]) runs[s]++;
            if (exp_q[s].size() == 0) check_bit($sformatf("dut%0d spare bit", s), v, 1'b0);
            else check_bit($sformatf("dut%0d stream bit", s), o, exp_q[s].pop_front());
        end else begin
            check_bit($sformatf("dut%0d idle filler", s), o, idle);
        end
        prev_valid[s] = (v === 1'b1);
        if (int'(lvl) == FD) check_bit($sformatf("dut%0d ready while full", s), rdy, 1'b0);
        if (int'(lvl) > max_lvl[s]) max_lvl[s] = int'(lvl);
    endtask

    task automatic cycle();
        @(negedge clk);
        ready_seen[0] = bus0.in_ready;
        ready_seen[1] = bus1.in_ready;
        if (rst_n) begin
            mon_one(0, bus0.stream_valid, bus0.stream_out, bus0.fifo_level, bus0.in_ready, 1'b0);
            mon_one(1, bus1.stream_valid, bus1.stream_out, bus1.fifo_level, bus1.in_ready, 1'b1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int s, input logic [7:0] w);
        bit acc = 1'b0;
        if (s == 0) begin
            bus0.in_data  = w;
            bus0.in_valid = 1'b1;
        end else begin
            bus1.in_data  = w;
            bus1.in_valid = 1'b1;
        end
        for (int n = 0; n < 40 && !acc; n++) begin
            cycle();
            acc = (ready_seen[s] === 1'b1);
        end
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        if (acc) queue_bits(s, w);
        check_bit($sformatf("dut%0d push accepted", s), acc, 1'b1);
    endtask

    task automatic wait_idle(input int limit);
        bit done = 1'b0;
        for (int n = 0; n < limit && !done; n++) begin
            cycle();
            done = !bus0.busy && !bus1.busy && exp_q[0].size() == 0 && exp_q[1].size() == 0;
        end
        check_bit("drain within budget", done, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0;
        int r0;
        logic [7:0] six [6];
        six = '{8'h11, 8'hA2, 8'h3C, 8'hF0, 8'h5E, 8'h87};
        valid_cnt  = '{0, 0};
        runs       = '{0, 0};
        max_lvl    = '{0, 0};
        prev_valid = '{1'b0, 1'b0};
        bus0.in_valid = 1'b0;
        bus0.in_data  = '0;
        bus1.in_valid = 1'b0;
        bus1.in_data  = '0;

        // Reset held while the producer pulses valid.
        repeat (2) cycle();
        bus0.in_valid = 1'b1;
        bus0.in_data  = 8'h55;
        bus1.in_valid = 1'b1;
        bus1.in_data  = 8'h55;
        cycle();
        check_bit("reset in_ready", bus0.in_ready, 1'b0);
        check_bit("reset stream_out", bus0.stream_out, 1'b0);
        check_bit("reset stream_valid", bus0.stream_valid, 1'b0);
        check_num("reset fifo_level", int'(bus0.fifo_level), 0);
        check_bit("reset busy", bus0.busy, 1'b0);
        check_bit("reset idle-high stream_out", bus1.stream_out, 1'b1);
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check_bit("in_ready before first edge", bus0.in_ready, 1'b0);
        cycle();
        check_bit("in_ready after first edge", bus0.in_ready, 1'b1);
        check_num("level after release", int'(bus0.fifo_level), 0);

        // Single word: first bit one cycle after acceptance, exactly 8 valid cycles.
        v0 = valid_cnt[0];
        r0 = runs[0];
        push_word(0, 8'h1A);
        check_bit("valid at acceptance edge", bus0.stream_valid, 1'b0);
        cycle();
        check_bit("valid one edge later", bus0.stream_valid, 1'b1);
        check_bit("first bit of 1A", bus0.stream_out, 1'b0);
        check_bit("busy while shifting", bus0.busy, 1'b1);
        wait_idle(20);
        check_num("1A valid cycles", valid_cnt[0] - v0, 8);
        check_num("1A valid runs", runs[0] - r0, 1);
        check_bit("busy after drain", bus0.busy, 1'b0);

        // Three back-to-back words form one unbroken 24-bit run.
        v0 = valid_cnt[0];
        r0 = runs[0];
        max_lvl[0] = 0;
        push_word(0, 8'h1A);
        push_word(0, 8'hD6);
        push_word(0, 8'h1A);
        wait_idle(40);
        check_num("b2b valid cycles", valid_cnt[0] - v0, 24);
        check_num("b2b valid runs", runs[0] - r0, 1);
        check_bit("b2b level never above 3", max_lvl[0] <= 3, 1'b1);

        // Six words against a 4-deep FIFO: backpressure, no loss, order kept.
        v0 = valid_cnt[0];
        max_lvl[0] = 0;
        for (int i = 0; i < 6; i++) push_word(0, six[i]);
        wait_idle(80);
        check_num("six-word valid cycles", valid_cnt[0] - v0, 48);
        check_num("six-word peak level", max_lvl[0], 4);

        // Reset at bit 3 of a word with two words buffered.
        push_word(0, 8'hA5);
        push_word(0, 8'h3C);
        push_word(0, 8'hC3);
        cycle();
        cycle();
        check_num("level before mid-word reset", int'(bus0.fifo_level), 2);
        rst_n = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        #1;
        check_bit("mid reset stream_valid", bus0.stream_valid, 1'b0);
        check_num("mid reset fifo_level", int'(bus0.fifo_level), 0);
        check_bit("mid reset busy", bus0.busy, 1'b0);
        check_bit("mid reset in_ready", bus0.in_ready, 1'b0);
        check_bit("mid reset stream_out", bus0.stream_out, 1'b0);
        cycle();
        rst_n = 1'b1;
        v0 = valid_cnt[0];
        push_word(0, 8'hFF);
        wait_idle(20);
        check_num("post-reset valid cycles", valid_cnt[0] - v0, 8);

        // LSB-first with idle-high filler.
        check_bit("lsb idle filler", bus1.stream_out, 1'b1);
        v0 = valid_cnt[1];
        push_word(1, 8'h01);
        cycle();
        check_bit("lsb first bit", bus1.stream_out, 1'b1);
        wait_idle(20);
        check_num("lsb valid cycles", valid_cnt[1] - v0, 8);
        check_bit("lsb idle after word", bus1.stream_out, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
